// File: rtl/conv_mac_engine_pkg.sv
// Shared definitions for the convolution / fully-connected engines:
// default geometry, data typedefs, FSM encoding and the output scaling helper.
package conv_pkg;

  localparam int DEF_BITWIDTH = 16;
  localparam int DEF_KSIZE    = 5;
  localparam int SAT_W        = 64;

  typedef logic signed [DEF_BITWIDTH-1:0]   data_t;
  typedef logic signed [2*DEF_BITWIDTH-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Round half up, arithmetic shift, then clamp to a bw-bit signed range.
  // Work is done at SAT_W bits so any engine accumulator up to 64 bits fits.
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             shift,
    input int unsigned             bw
  );
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    if (shift > 32'd0) begin
      t = acc + (64'sd1 <<< (shift - 32'd1));
    end else begin
      t = acc;
    end
    r  = t >>> shift;
    hi = (64'sd1 <<< (bw - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 32'd1));
    if (r > hi) begin
      sat_round = hi;
    end else if (r < lo) begin
      sat_round = lo;
    end else begin
      sat_round = r;
    end
  endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// Beat-in / result-out handshake bundle of the convolution MAC engine.
// master = window generator + feature-map writer side, slave = engine.
interface conv_mac_engine_if
  import conv_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int KSIZE    = DEF_KSIZE
);

  logic                                in_valid;
  logic                                in_ready;
  logic [KSIZE*KSIZE*BITWIDTH-1:0]     map_block;
  logic [KSIZE*KSIZE*BITWIDTH-1:0]     kernel;
  logic signed [BITWIDTH-1:0]          bias;
  logic                                relu_en;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [BITWIDTH-1:0]          value;

  modport master (
    output in_valid, map_block, kernel, bias, relu_en, out_ready,
    input  in_ready, out_valid, value
  );

  modport slave (
    input  in_valid, map_block, kernel, bias, relu_en, out_ready,
    output in_ready, out_valid, value
  );

endinterface

// File: rtl/conv_mac_engine_row_mac.sv
// One window row times one kernel row: KSIZE signed products summed at full
// precision. Purely combinational.
module conv_row_mac
  import conv_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int KSIZE    = DEF_KSIZE
) (
  input  logic [KSIZE*BITWIDTH-1:0]                   map_row,
  input  logic [KSIZE*BITWIDTH-1:0]                   ker_row,
  output logic signed [2*BITWIDTH+$clog2(KSIZE)-1:0] row_sum
);

  localparam int PW = 2 * BITWIDTH;
  localparam int SW = 2 * BITWIDTH + $clog2(KSIZE);

  logic signed [PW-1:0] prod_s [KSIZE];

  for (genvar c = 0; c < KSIZE; c++) begin : g_mul
    assign prod_s[c] = $signed(map_row[c*BITWIDTH +: BITWIDTH]) *
                       $signed(ker_row[c*BITWIDTH +: BITWIDTH]);
  end

  // Sign-extended sum of the row products; the $clog2(KSIZE) guard bits absorb growth.
  always_comb begin
    row_sum = {SW{1'b0}};
    for (int c = 0; c < KSIZE; c++) begin
      row_sum = row_sum + SW'(prod_s[c]);
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Sequential convolution point: NCH window/kernel beats reduced one row per
// cycle into a wide accumulator, then biased, rounded, shifted, saturated, ReLU'd.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int KSIZE    = DEF_KSIZE,
  parameter int NCH      = 4,
  parameter int SHIFT    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_mac_engine_if.slave bus
);

  localparam int ACCW = 2*BITWIDTH + $clog2(KSIZE*KSIZE*NCH) + 1;
  localparam int WIN  = KSIZE * KSIZE * BITWIDTH;
  localparam int ROWW = KSIZE * BITWIDTH;
  localparam int SUMW = 2*BITWIDTH + $clog2(KSIZE);
  localparam int RW   = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(KSIZE - 1);
  localparam logic [CW-1:0] CH_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CH_ONE   = CW'(1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

  state_e                     state_q,     state_d;
  logic [RW-1:0]              row_cnt_q,   row_cnt_d;
  logic [CW-1:0]              ch_cnt_q,    ch_cnt_d;
  logic [WIN-1:0]             map_q,       map_d;
  logic [WIN-1:0]             ker_q,       ker_d;
  logic signed [BITWIDTH-1:0] bias_q,      bias_d;
  logic                       relu_q,      relu_d;
  logic signed [ACCW-1:0]     acc_q,       acc_d;
  logic signed [BITWIDTH-1:0] value_q,     value_d;
  logic                       in_ready_q,  in_ready_d;
  logic                       out_valid_q, out_valid_d;

  logic [ROWW-1:0]            map_row_s;
  logic [ROWW-1:0]            ker_row_s;
  logic signed [SUMW-1:0]     row_sum_s;
  logic signed [ACCW-1:0]     acc_sum_s;
  logic signed [ACCW-1:0]     biased_s;
  logic signed [SAT_W-1:0]    sat_s;
  logic                       accept_s;
  logic                       deliver_s;

  assign map_row_s = map_q[int'(row_cnt_q)*ROWW +: ROWW];
  assign ker_row_s = ker_q[int'(row_cnt_q)*ROWW +: ROWW];

  conv_row_mac #(
    .BITWIDTH (BITWIDTH),
    .KSIZE    (KSIZE)
  ) u_row_mac (
    .map_row (map_row_s),
    .ker_row (ker_row_s),
    .row_sum (row_sum_s)
  );

  assign accept_s  = bus.in_valid && in_ready_q;
  assign deliver_s = out_valid_q && bus.out_ready;

  // The final value is formed from the accumulator including the row being added now.
  assign acc_sum_s = acc_q + ACCW'(row_sum_s);
  assign biased_s  = acc_sum_s + (ACCW'(bias_q) <<< SHIFT);
  assign sat_s     = sat_round(SAT_W'(biased_s), SHIFT, BITWIDTH);

  // Next-state and datapath updates for IDLE -> MAC (x KSIZE rows) -> IDLE/OUT.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    map_d     = map_q;
    ker_d     = ker_q;
    bias_d    = bias_q;
    relu_d    = relu_q;
    acc_d     = acc_q;
    value_d   = value_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          map_d     = bus.map_block;
          ker_d     = bus.kernel;
          row_cnt_d = ROW_ZERO;
          if (ch_cnt_q == CH_ZERO) begin
            bias_d = bus.bias;
            relu_d = bus.relu_en;
          end else begin
            bias_d = bias_q;
            relu_d = relu_q;
          end
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_sum_s;
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_d = ROW_ZERO;
          if (ch_cnt_q == CH_LAST) begin
            if (relu_q && (sat_s < 64'sd0)) begin
              value_d = {BITWIDTH{1'b0}};
            end else begin
              value_d = sat_s[BITWIDTH-1:0];
            end
            state_d = OUT;
          end else begin
            ch_cnt_d = ch_cnt_q + CH_ONE;
            state_d  = IDLE;
          end
        end else begin
          row_cnt_d = row_cnt_q + ROW_ONE;
          state_d   = MAC;
        end
      end
      OUT: begin
        if (deliver_s) begin
          acc_d    = {ACCW{1'b0}};
          ch_cnt_d = CH_ZERO;
          state_d  = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        acc_d     = {ACCW{1'b0}};
        ch_cnt_d  = CH_ZERO;
        row_cnt_d = ROW_ZERO;
        state_d   = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  // State and datapath registers; reset drops any partial or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= ROW_ZERO;
      ch_cnt_q    <= CH_ZERO;
      map_q       <= {WIN{1'b0}};
      ker_q       <= {WIN{1'b0}};
      bias_q      <= {BITWIDTH{1'b0}};
      relu_q      <= 1'b0;
      acc_q       <= {ACCW{1'b0}};
      value_q     <= {BITWIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      map_q       <= map_d;
      ker_q       <= ker_d;
      bias_q      <= bias_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      value_q     <= value_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.value     = value_q;

endmodule
